bcd_updown_counter: RTL and testbench
=====================================

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter NDIG, default 4, number of BCD digits; legal range 1..8.
REQ-002 Port clk_10Hz  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  reset; synchronous, active-high despite the name; clears all state when high at a rising edge of clk_10Hz.
REQ-004 Port en  input  1  count enable; one step per clock while high.
REQ-005 Port up  input  1  direction; 1 = increment, 0 = decrement.
REQ-006 Port load  input  1  synchronous parallel load strobe.
REQ-007 Port load_val  input  4*NDIG  BCD load value; digit k occupies bits [4k+3:4k], digit 0 is ones.
REQ-008 Port count  output  4*NDIG  registered BCD count, same digit packing as load_val.
REQ-009 Port wrap  output  1  registered; high for one cycle when count wraps.
REQ-010 Port load_err  output  1  registered; high for one cycle after a load containing any digit >9.

Function
REQ-011 Priority per clock SHALL be: rst_n > load > en; if none is active, count holds.
REQ-012 Load SHALL write load_val into count on the same edge; any digit >9 is written as 0, other digits load unchanged.
REQ-013 load_err SHALL be 1 in the cycle after a load with at least one digit >9, else 0.
REQ-014 Up step: digit 0 SHALL increment; digit k>0 increments only when all lower digits equal 9; a digit equal to 9 that steps becomes 0.
REQ-015 Down step: digit 0 SHALL decrement; digit k>0 decrements only when all lower digits equal 0; a digit equal to 0 that steps becomes 9.
REQ-016 Up step from all-9 SHALL give all-0 and set wrap; down step from all-0 SHALL give all-9 and set wrap.
REQ-017 wrap SHALL be high exactly in the cycle in which count shows the post-wrap value, and 0 in every other cycle, including cycles with load or with en low.
REQ-018 Latency: count SHALL reflect a step or load one clock after the edge sampling en/load; no combinational path from any input to any output.
REQ-019 Direction changes SHALL take effect on the next enabled step, with no idle cycle.
REQ-020 Digits SHALL never hold a value >9 under any input sequence.

Reset
REQ-021 While rst_n is high at a clock edge, count SHALL become all-0, wrap 0, load_err 0, overriding load and en.
REQ-022 Reset asserted mid-count SHALL discard any pending step; counting resumes from 0 on the first edge with rst_n low and en high.
REQ-023 Without reset, output values before the first reset are undefined; no initial values are relied on.

Configuration
REQ-024 Macro BCD_CNT_SATURATE_EN SHALL select end-of-range behaviour.
REQ-025 Without BCD_CNT_SATURATE_EN: wrap-around per REQ-016.
REQ-026 With BCD_CNT_SATURATE_EN: an up step at all-9 and a down step at all-0 SHALL leave count unchanged, wrap SHALL be permanently 0, and all other behaviour is unchanged.

Verification
REQ-027 NDIG=4, reset, then en=1 up=1 for 1000 clocks -> count=1000 BCD (0x1000), wrap never high.
REQ-028 Load 0x9998, en=1 up=1 for 3 clocks -> count 0x9999, 0x0000 with wrap=1, 0x0001 with wrap=0; with BCD_CNT_SATURATE_EN: 0x9999, 0x9999, 0x9999, wrap=0.
REQ-029 Load 0x0001, en=1 up=0 for 2 clocks -> 0x0000, 0x9999 with wrap=1; load 0x1000, one down step -> 0x0999.
REQ-030 Load 0x3A7F -> count=0x3070 and load_err=1 for one cycle; load and en both high with load_val 0x0042 -> count=0x0042, no step.
REQ-031 Count to 0x0123, then rst_n=1 for one clock with load=1 and en=1 -> count=0x0000, wrap=0, load_err=0; en low for 5 clocks -> count holds.
REQ-032 NDIG=1 and NDIG=8 builds: up from 9 -> 0 with wrap; up from 0x99999999 -> 0 with wrap.

Source files
------------

// File: rtl/bcd_updown_counter_if.sv
// Control and data bundle for bcd_updown_counter. NDIG sets the width of
// load_val and count, which hold one 4-bit BCD digit per decade with digit 0 as ones.
interface bcd_updown_counter_if #(
    parameter int NDIG = 4
);
    logic              en;
    logic              up;
    logic              load;
    logic [4*NDIG-1:0] load_val;
    logic [4*NDIG-1:0] count;
    logic              wrap;
    logic              load_err;

    modport master (
        output en, up, load, load_val,
        input  count, wrap, load_err
    );

    modport slave (
        input  en, up, load, load_val,
        output count, wrap, load_err
    );
endinterface

// File: rtl/bcd_updown_counter.sv
// NDIG-digit BCD up/down counter with parallel load, wrap flag and invalid-digit flag.
// Define BCD_CNT_SATURATE_EN to make the count stop at the range ends instead of wrapping.
module bcd_updown_counter #(
    parameter int NDIG = 4
) (
    input  logic                 clk_10Hz,
    input  logic                 rst_n,
    bcd_updown_counter_if.slave  bus
);
    logic [4*NDIG-1:0] count_reg, count_next;
    logic              wrap_reg, wrap_next;
    logic              load_err_reg, load_err_next;

    logic [4*NDIG-1:0] up_val, down_val, load_fix;
    logic [NDIG:0]     nine_chain, zero_chain;
    logic [NDIG-1:0]   digit_bad;

    // chain[k] is high when every digit below k is 9 (or 0), so digit k moves on this step
    assign nine_chain[0] = 1'b1;
    assign zero_chain[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
            logic [3:0] cur;
            logic [3:0] ld;

            assign cur = count_reg[4*gi +: 4];
            assign ld  = bus.load_val[4*gi +: 4];

            assign nine_chain[gi+1] = nine_chain[gi] & (cur == 4'd9);
            assign zero_chain[gi+1] = zero_chain[gi] & (cur == 4'd0);

            assign up_val[4*gi +: 4]   = !nine_chain[gi] ? cur :
                                         (cur == 4'd9) ? 4'd0 : cur + 4'd1;
            assign down_val[4*gi +: 4] = !zero_chain[gi] ? cur :
                                         (cur == 4'd0) ? 4'd9 : cur - 4'd1;

            assign digit_bad[gi]         = (ld > 4'd9);
            assign load_fix[4*gi +: 4]   = digit_bad[gi] ? 4'd0 : ld;
        end
    endgenerate

    always_comb begin
        count_next    = count_reg;
        wrap_next     = 1'b0;
        load_err_next = 1'b0;
        if (bus.load) begin
            count_next    = load_fix;
            load_err_next = |digit_bad;
        end else if (bus.en) begin
            if (bus.up) begin
`ifdef BCD_CNT_SATURATE_EN
                if (!nine_chain[NDIG]) begin
                    count_next = up_val;
                end
`else
                // up_val is already all-0 when every digit is 9
                count_next = up_val;
                wrap_next  = nine_chain[NDIG];
`endif
            end else begin
`ifdef BCD_CNT_SATURATE_EN
                if (!zero_chain[NDIG]) begin
                    count_next = down_val;
                end
`else
                count_next = down_val;
                wrap_next  = zero_chain[NDIG];
`endif
            end
        end
    end

    always_ff @(posedge clk_10Hz) begin
        if (rst_n) begin
            count_reg    <= '0;
            wrap_reg     <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            wrap_reg     <= wrap_next;
            load_err_reg <= load_err_next;
        end
    end

    assign bus.count    = count_reg;
    assign bus.wrap     = wrap_reg;
    assign bus.load_err = load_err_reg;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench for bcd_updown_counter: directed scenarios plus randomized traffic
// against an integer-valued reference model; also exercises NDIG=1 and NDIG=8 instances.
module tb_bcd_updown_counter;
`ifdef BCD_CNT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int MAXV = 9999;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    int   m_val;
    bit   m_wrap;
    bit   m_err;

    bcd_updown_counter_if #(.NDIG(4)) bus4 ();
    bcd_updown_counter_if #(.NDIG(8)) bus8 ();
    bcd_updown_counter_if #(.NDIG(1)) bus1 ();

    bcd_updown_counter #(.NDIG(4)) dut4 (.clk_10Hz(clk), .rst_n(rst_n), .bus(bus4));
    bcd_updown_counter #(.NDIG(8)) dut8 (.clk_10Hz(clk), .rst_n(rst_n), .bus(bus8));
    bcd_updown_counter #(.NDIG(1)) dut1 (.clk_10Hz(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd4(input int v);
        logic [15:0] r;
        int          x;
        x = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int load_value(input logic [15:0] lv);
        int v;
        int w;
        v = 0;
        w = 1;
        for (int k = 0; k < 4; k++) begin
            if (lv[4*k +: 4] <= 4'd9) v = v + w * int'(lv[4*k +: 4]);
            w = w * 10;
        end
        return v;
    endfunction

    function automatic bit has_bad(input logic [15:0] lv);
        bit b;
        b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (lv[4*k +: 4] > 4'd9) b = 1'b1;
        end
        return b;
    endfunction

    // One clock of stimulus on the 4-digit instance, with the reference model stepped alongside
    task automatic cyc(input bit r, input bit e, input bit u, input bit l, input logic [15:0] lv);
        @(negedge clk);
        rst_n         = r;
        bus4.en       = e;
        bus4.up       = u;
        bus4.load     = l;
        bus4.load_val = lv;
        @(posedge clk);
        if (r) begin
            m_val = 0; m_wrap = 0; m_err = 0;
        end else if (l) begin
            m_val = load_value(lv); m_err = has_bad(lv); m_wrap = 0;
        end else begin
            m_err  = 0;
            m_wrap = 0;
            if (e && u) begin
                if (m_val == MAXV) begin
                    if (!SAT) begin m_val = 0; m_wrap = 1; end
                end else m_val = m_val + 1;
            end else if (e) begin
                if (m_val == 0) begin
                    if (!SAT) begin m_val = MAXV; m_wrap = 1; end
                end else m_val = m_val - 1;
            end
        end
        #1;
        txn++;
        $display("txn %0d rst=%b en=%b up=%b load=%b lv=%h -> count=%h wrap=%b load_err=%b",
                 txn, r, e, u, l, lv, bus4.count, bus4.wrap, bus4.load_err);
    endtask

    task automatic test_reset();
        cyc(1, 1, 1, 1, 16'h5678);
        checks++;
        if (bus4.count !== 16'h0000) begin
            errors++; $display("FAIL reset_count got %h want 0000", bus4.count);
        end
        checks++;
        if (bus4.wrap !== 1'b0 || bus4.load_err !== 1'b0) begin
            errors++; $display("FAIL reset_flags got wrap=%b err=%b want 0 0", bus4.wrap, bus4.load_err);
        end
    endtask

    task automatic test_count_1000();
        int wrap_seen;
        cyc(1, 0, 0, 0, 16'h0);
        wrap_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc(0, 1, 1, 0, 16'h0);
            if (bus4.wrap !== 1'b0) wrap_seen++;
        end
        checks++;
        if (bus4.count !== 16'h1000) begin
            errors++; $display("FAIL count_1000 got %h want 1000", bus4.count);
        end
        checks++;
        if (wrap_seen != 0) begin
            errors++; $display("FAIL count_1000_wrap got %0d wrap cycles want 0", wrap_seen);
        end
    endtask

    task automatic test_wrap_up();
        logic [15:0] exp_c[3];
        logic        exp_w[3];
        if (SAT) begin
            exp_c = '{16'h9999, 16'h9999, 16'h9999};
            exp_w = '{1'b0, 1'b0, 1'b0};
        end else begin
            exp_c = '{16'h9999, 16'h0000, 16'h0001};
            exp_w = '{1'b0, 1'b1, 1'b0};
        end
        cyc(0, 0, 0, 1, 16'h9998);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 0, 16'h0);
            checks++;
            if (bus4.count !== exp_c[i] || bus4.wrap !== exp_w[i]) begin
                errors++;
                $display("FAIL wrap_up step %0d got %h/%b want %h/%b",
                         i, bus4.count, bus4.wrap, exp_c[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_wrap_down();
        logic [15:0] exp_c[2];
        logic        exp_w[2];
        if (SAT) begin
            exp_c = '{16'h0000, 16'h0000};
            exp_w = '{1'b0, 1'b0};
        end else begin
            exp_c = '{16'h0000, 16'h9999};
            exp_w = '{1'b0, 1'b1};
        end
        cyc(0, 0, 0, 1, 16'h0001);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 0, 0, 16'h0);
            checks++;
            if (bus4.count !== exp_c[i] || bus4.wrap !== exp_w[i]) begin
                errors++;
                $display("FAIL wrap_down step %0d got %h/%b want %h/%b",
                         i, bus4.count, bus4.wrap, exp_c[i], exp_w[i]);
            end
        end
        cyc(0, 0, 0, 1, 16'h1000);
        cyc(0, 1, 0, 0, 16'h0);
        checks++;
        if (bus4.count !== 16'h0999 || bus4.wrap !== 1'b0) begin
            errors++; $display("FAIL borrow_chain got %h/%b want 0999/0", bus4.count, bus4.wrap);
        end
    endtask

    task automatic test_load_err();
        cyc(0, 0, 0, 1, 16'h3A7F);
        checks++;
        if (bus4.count !== 16'h3070 || bus4.load_err !== 1'b1) begin
            errors++; $display("FAIL load_bad got %h/%b want 3070/1", bus4.count, bus4.load_err);
        end
        cyc(0, 0, 0, 0, 16'h0);
        checks++;
        if (bus4.count !== 16'h3070 || bus4.load_err !== 1'b0) begin
            errors++; $display("FAIL load_err_clear got %h/%b want 3070/0", bus4.count, bus4.load_err);
        end
        cyc(0, 1, 1, 1, 16'h0042);
        checks++;
        if (bus4.count !== 16'h0042 || bus4.load_err !== 1'b0 || bus4.wrap !== 1'b0) begin
            errors++;
            $display("FAIL load_over_en got %h/%b/%b want 0042/0/0", bus4.count, bus4.load_err, bus4.wrap);
        end
    endtask

    task automatic test_reset_mid();
        cyc(0, 0, 0, 1, 16'h0120);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 16'h0);
        checks++;
        if (bus4.count !== 16'h0123) begin
            errors++; $display("FAIL pre_reset got %h want 0123", bus4.count);
        end
        cyc(1, 1, 1, 1, 16'h5555);
        checks++;
        if (bus4.count !== 16'h0000 || bus4.wrap !== 1'b0 || bus4.load_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got %h/%b/%b want 0000/0/0", bus4.count, bus4.wrap, bus4.load_err);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, ($urandom % 2) == 1, 0, 16'h0);
            checks++;
            if (bus4.count !== 16'h0000 || bus4.wrap !== 1'b0) begin
                errors++; $display("FAIL hold %0d got %h/%b want 0000/0", i, bus4.count, bus4.wrap);
            end
        end
        cyc(0, 1, 1, 0, 16'h0);
        checks++;
        if (bus4.count !== 16'h0001) begin
            errors++; $display("FAIL resume got %h want 0001", bus4.count);
        end
    endtask

    task automatic test_random();
        bit          r, e, u, l;
        logic [15:0] lv;
        int          sel;
        for (int i = 0; i < 2500; i++) begin
            r   = ($urandom % 60) == 0;
            l   = ($urandom % 10) == 0;
            e   = ($urandom % 4) != 0;
            u   = ($urandom % 2) == 1;
            sel = $urandom % 3;
            if (sel == 0)      lv = to_bcd4(9990 + int'($urandom % 10));
            else if (sel == 1) lv = to_bcd4(int'($urandom % 10));
            else               lv = 16'($urandom);
            cyc(r, e, u, l, lv);
            checks++;
            if (bus4.count !== to_bcd4(m_val) || bus4.wrap !== m_wrap || bus4.load_err !== m_err) begin
                errors++;
                $display("FAIL random %0d got %h/%b/%b want %h/%b/%b", i, bus4.count, bus4.wrap,
                         bus4.load_err, to_bcd4(m_val), m_wrap, m_err);
            end
        end
    endtask

    task automatic test_ndig_variants();
        logic [31:0] exp8[2];
        logic [3:0]  exp1[2];
        logic        expw[2];
        if (SAT) begin
            exp8 = '{32'h99999999, 32'h99999999};
            exp1 = '{4'h9, 4'h9};
            expw = '{1'b0, 1'b0};
        end else begin
            exp8 = '{32'h00000000, 32'h00000001};
            exp1 = '{4'h0, 4'h1};
            expw = '{1'b1, 1'b0};
        end
        @(negedge clk);
        rst_n = 1'b0;
        bus8.load = 1'b1; bus8.load_val = 32'h99999998;
        bus1.load = 1'b1; bus1.load_val = 4'h8;
        @(posedge clk); #1;
        checks++;
        if (bus8.count !== 32'h99999998 || bus1.count !== 4'h8) begin
            errors++; $display("FAIL ndig_load got %h/%h want 99999998/8", bus8.count, bus1.count);
        end
        @(negedge clk);
        bus8.load = 1'b0; bus8.en = 1'b1; bus8.up = 1'b1;
        bus1.load = 1'b0; bus1.en = 1'b1; bus1.up = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus8.count !== 32'h99999999 || bus1.count !== 4'h9 || bus8.wrap !== 1'b0 || bus1.wrap !== 1'b0) begin
            errors++; $display("FAIL ndig_top got %h/%h want 99999999/9", bus8.count, bus1.count);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus8.count !== exp8[i] || bus8.wrap !== expw[i]) begin
                errors++;
                $display("FAIL ndig8 step %0d got %h/%b want %h/%b", i, bus8.count, bus8.wrap, exp8[i], expw[i]);
            end
            checks++;
            if (bus1.count !== exp1[i] || bus1.wrap !== expw[i]) begin
                errors++;
                $display("FAIL ndig1 step %0d got %h/%b want %h/%b", i, bus1.count, bus1.wrap, exp1[i], expw[i]);
            end
        end
        @(negedge clk);
        bus8.en = 1'b0;
        bus1.en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        bus4.en = 1'b0; bus4.up = 1'b0; bus4.load = 1'b0; bus4.load_val = '0;
        bus8.en = 1'b0; bus8.up = 1'b0; bus8.load = 1'b0; bus8.load_val = '0;
        bus1.en = 1'b0; bus1.up = 1'b0; bus1.load = 1'b0; bus1.load_val = '0;
        m_val = 0; m_wrap = 0; m_err = 0;

        test_reset();
        test_count_1000();
        test_wrap_up();
        test_wrap_down();
        test_load_err();
        test_reset_mid();
        test_random();
        test_ndig_variants();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
